// File: rtl/rotated_frame_sink_if.sv
// Pixel stream bundle between the sprite rotator and the frame sink.
// The producer (master) drives the pixel code, its destination coordinates and valid.
// The sink (slave) returns o_ready once its write bank has been cleared.
interface rotated_frame_sink_if #(
   parameter int H_WIDTH   = 6,
   parameter int V_WIDTH   = 6,
   parameter int PIX_WIDTH = 4
);
   logic [PIX_WIDTH-1:0] i_encoded_pixel;
   logic [H_WIDTH-1:0]   i_H_transformed;
   logic [V_WIDTH-1:0]   i_V_transformed;
   logic                 i_valid;
   logic                 o_ready;

   modport master (
      output i_encoded_pixel, i_H_transformed, i_V_transformed, i_valid,
      input  o_ready
   );

   modport slave (
      input  i_encoded_pixel, i_H_transformed, i_V_transformed, i_valid,
      output o_ready
   );
endinterface

// File: rtl/rotated_frame_sink.sv
// rotated_frame_sink: receiving end of the rotated-sprite pixel stream.
// Incoming pixels are scattered into the write bank of a double-buffered frame store
// addressed {V,H}; the banks swap when a frame ends (valid falls) and the finished bank
// is served to scanout through a registered, 1-cycle-latency read port.
// Before each frame the write bank is cleared to TRANSPARENT, one entry per cycle.
// Optional feature macro: SKIP_TRANSPARENT_EN -- when defined, stream pixels equal to
// TRANSPARENT are not written, so they never overwrite earlier pixels of the frame.
module rotated_frame_sink #(
   parameter int                   H_WIDTH     = 6,
   parameter int                   V_WIDTH     = 6,
   parameter int                   PIX_WIDTH   = 4,
   parameter logic [PIX_WIDTH-1:0] TRANSPARENT = '0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   rotated_frame_sink_if.slave  stream,
   output logic                 o_frame_done,
   output logic                 o_overrun,
   input  logic                 i_clr_overrun,
   input  logic                 i_rd_en,
   input  logic [H_WIDTH-1:0]   i_rd_h,
   input  logic [V_WIDTH-1:0]   i_rd_v,
   output logic [PIX_WIDTH-1:0] o_rd_pixel,
   output logic                 o_rd_valid,
   output logic                 o_disp_valid
);

   localparam int ADDR_W = H_WIDTH + V_WIDTH;
   localparam int DEPTH  = 2 ** (ADDR_W + 1);

   typedef enum logic [1:0] {CLEAR, READY, FILL, SWAP} state_t;

   state_t               state_q;
   logic [ADDR_W-1:0]    cnt_q;
   logic                 wr_bank_q;
   logic                 rd_bank_q;
   logic                 ready_q;
   logic                 frame_done_q;
   logic                 overrun_q;
   logic                 disp_valid_q;
   logic [PIX_WIDTH-1:0] rd_pixel_q;
   logic                 rd_valid_q;

   // Both banks live in one array; the MSB of the address selects the bank.
   logic [PIX_WIDTH-1:0] mem_q [0:DEPTH-1];

   logic                 wr_en_d;
   logic [ADDR_W:0]      wr_addr_d;
   logic [PIX_WIDTH-1:0] wr_data_d;
   logic                 pix_keep;

`ifdef SKIP_TRANSPARENT_EN
   assign pix_keep = (stream.i_encoded_pixel != TRANSPARENT);
`else
   assign pix_keep = 1'b1;
`endif

   // Single write port: the clear sweep in CLEAR, stream pixels in READY/FILL.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = {wr_bank_q, cnt_q};
      wr_data_d = TRANSPARENT;
      case (state_q)
         CLEAR: wr_en_d = 1'b1;
         READY, FILL: begin
            if (stream.i_valid) begin
               wr_en_d   = pix_keep;
               wr_addr_d = {wr_bank_q, stream.i_V_transformed, stream.i_H_transformed};
               wr_data_d = stream.i_encoded_pixel;
            end
         end
         default: ;
      endcase
   end

   // Frame store write; contents are deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (wr_en_d) mem_q[wr_addr_d] <= wr_data_d;
   end

   // Frame sequencing FSM, overrun flag and registered scanout read port.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= CLEAR;
         cnt_q        <= '0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b1;
         ready_q      <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         disp_valid_q <= 1'b0;
         rd_pixel_q   <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_q <= READY;
                  ready_q <= 1'b1;
               end
            end
            READY: begin
               if (stream.i_valid) state_q <= FILL;
            end
            FILL: begin
               // The first idle cycle closes the frame.
               if (!stream.i_valid) begin
                  state_q      <= SWAP;
                  ready_q      <= 1'b0;
                  frame_done_q <= 1'b1;
               end
            end
            SWAP: begin
               // Banks flip on leaving SWAP so a read issued during SWAP still sees the old frame.
               state_q      <= CLEAR;
               cnt_q        <= '0;
               wr_bank_q    <= ~wr_bank_q;
               rd_bank_q    <= ~rd_bank_q;
               disp_valid_q <= 1'b1;
            end
            default: state_q <= CLEAR;
         endcase

         // A pixel arriving while the bank is not accepting is lost; setting beats clearing.
         if (stream.i_valid && (state_q == CLEAR || state_q == SWAP)) overrun_q <= 1'b1;
         else if (i_clr_overrun)                                     overrun_q <= 1'b0;

         if (i_rd_en) begin
            rd_valid_q <= 1'b1;
            rd_pixel_q <= disp_valid_q ? mem_q[{rd_bank_q, i_rd_v, i_rd_h}] : TRANSPARENT;
         end else begin
            rd_valid_q <= 1'b0;
         end
      end
   end

   assign stream.o_ready = ready_q;
   assign o_frame_done   = frame_done_q;
   assign o_overrun      = overrun_q;
   assign o_rd_pixel     = rd_pixel_q;
   assign o_rd_valid     = rd_valid_q;
   assign o_disp_valid   = disp_valid_q;

endmodule

// File: tb/tb_rotated_frame_sink.sv
// Directed bench for rotated_frame_sink: clear timing, frame fill and swap, scanout reads,
// duplicate coordinates, overrun flag, read during swap, transparent writes, mid-frame reset.
module tb_rotated_frame_sink;

   logic       clk;
   logic       rst;
   logic       clr_overrun;
   logic       rd_en;
   logic [5:0] rd_h;
   logic [5:0] rd_v;
   logic       frame_done;
   logic       overrun;
   logic [3:0] rd_pixel;
   logic       rd_valid;
   logic       disp_valid;

   int checks;
   int errors;

   rotated_frame_sink_if #(.H_WIDTH(6), .V_WIDTH(6), .PIX_WIDTH(4)) sif ();

   rotated_frame_sink dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .stream        (sif),
      .o_frame_done  (frame_done),
      .o_overrun     (overrun),
      .i_clr_overrun (clr_overrun),
      .i_rd_en       (rd_en),
      .i_rd_h        (rd_h),
      .i_rd_v        (rd_v),
      .o_rd_pixel    (rd_pixel),
      .o_rd_valid    (rd_valid),
      .o_disp_valid  (disp_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] h, input logic [5:0] v, input logic [3:0] p);
      sif.i_valid = 1'b1;
      sif.i_H_transformed = h;
      sif.i_V_transformed = v;
      sif.i_encoded_pixel = p;
      tick();
   endtask

   task automatic do_read(input logic [5:0] h, input logic [5:0] v,
                          output logic [3:0] pix, output logic vld);
      rd_en = 1'b1;
      rd_h  = h;
      rd_v  = v;
      tick();
      rd_en = 1'b0;
      pix   = rd_pixel;
      vld   = rd_valid;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (sif.o_ready !== 1'b1 && n < 5000) begin
         tick();
         n++;
      end
      checks++;
      if (sif.o_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready o_ready=%b after %0d cycles, required 1", sif.o_ready, n);
      end
   endtask

   task automatic test_reset();
      int n;
      logic [3:0] p;
      logic v;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({sif.o_ready, frame_done, overrun, rd_pixel, rd_valid, disp_valid} !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs got ready=%b fd=%b ovr=%b pix=%h rv=%b dv=%b required all 0",
                  sif.o_ready, frame_done, overrun, rd_pixel, rd_valid, disp_valid);
      end
      rst = 1'b0;
      n = 0;
      while (sif.o_ready !== 1'b1 && n < 5000) begin
         tick();
         n++;
      end
      checks++;
      if (n != 4096) begin
         errors++;
         $display("FAIL clear_length o_ready rose after %0d cycles, required 4096", n);
      end
      checks++;
      if (disp_valid !== 1'b0) begin
         errors++;
         $display("FAIL disp_valid_initial got %b required 0", disp_valid);
      end
      do_read(6'd5, 6'd5, p, v);
      checks++;
      if (p !== 4'h0 || v !== 1'b1) begin
         errors++;
         $display("FAIL read_no_frame got pix=%h vld=%b required pix=0 vld=1", p, v);
      end
   endtask

   task automatic test_frame_basic();
      logic [3:0] p;
      logic v;
      push(6'd1, 6'd2, 4'b1010);
      push(6'd63, 6'd63, 4'b0111);
      push(6'd0, 6'd0, 4'b0001);
      sif.i_valid = 1'b0;
      tick();
      checks++;
      if (frame_done !== 1'b1 || sif.o_ready !== 1'b0) begin
         errors++;
         $display("FAIL swap_cycle got fd=%b ready=%b required fd=1 ready=0", frame_done, sif.o_ready);
      end
      tick();
      checks++;
      if (frame_done !== 1'b0 || disp_valid !== 1'b1) begin
         errors++;
         $display("FAIL after_swap got fd=%b dv=%b required fd=0 dv=1", frame_done, disp_valid);
      end
      do_read(6'd1, 6'd2, p, v);
      checks++;
      if (p !== 4'b1010 || v !== 1'b1) begin
         errors++;
         $display("FAIL read_1_2 got pix=%b vld=%b required 1010 1", p, v);
      end
      do_read(6'd5, 6'd5, p, v);
      checks++;
      if (p !== 4'b0000) begin
         errors++;
         $display("FAIL read_5_5 got %b required 0000", p);
      end
      do_read(6'd63, 6'd63, p, v);
      checks++;
      if (p !== 4'b0111) begin
         errors++;
         $display("FAIL read_63_63 got %b required 0111", p);
      end
      tick();
      checks++;
      if (rd_pixel !== 4'b0111 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_hold got pix=%b vld=%b required 0111 0", rd_pixel, rd_valid);
      end
   endtask

   task automatic test_second_frame();
      logic [3:0] p;
      logic v;
      wait_ready();
      rd_en = 1'b1;
      rd_h  = 6'd1;
      rd_v  = 6'd2;
      push(6'd1, 6'd2, 4'b0011);
      rd_en = 1'b0;
      checks++;
      if (rd_pixel !== 4'b1010) begin
         errors++;
         $display("FAIL read_during_fill got %b required 1010", rd_pixel);
      end
      sif.i_valid = 1'b0;
      tick();
      tick();
      do_read(6'd1, 6'd2, p, v);
      checks++;
      if (p !== 4'b0011) begin
         errors++;
         $display("FAIL second_frame_1_2 got %b required 0011", p);
      end
      do_read(6'd63, 6'd63, p, v);
      checks++;
      if (p !== 4'b0000) begin
         errors++;
         $display("FAIL second_frame_63_63 got %b required 0000", p);
      end
   endtask

   task automatic test_overrun();
      push(6'd7, 6'd7, 4'b1111);
      sif.i_valid = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set got %b required 1", overrun);
      end
      tick();
      tick();
      tick();
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky got %b required 1", overrun);
      end
      clr_overrun = 1'b1;
      push(6'd8, 6'd8, 4'b1111);
      sif.i_valid = 1'b0;
      clr_overrun = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set_wins got %b required 1", overrun);
      end
   endtask

   task automatic test_duplicate();
      logic [3:0] p;
      logic v;
      wait_ready();
      push(6'd3, 6'd3, 4'b0101);
      push(6'd3, 6'd3, 4'b1100);
      sif.i_valid = 1'b0;
      tick();
      tick();
      do_read(6'd3, 6'd3, p, v);
      checks++;
      if (p !== 4'b1100) begin
         errors++;
         $display("FAIL duplicate_last_wins got %b required 1100", p);
      end
      do_read(6'd7, 6'd7, p, v);
      checks++;
      if (p !== 4'b0000) begin
         errors++;
         $display("FAIL dropped_pixel_7_7 got %b required 0000", p);
      end
      do_read(6'd63, 6'd63, p, v);
      checks++;
      if (p !== 4'b0000) begin
         errors++;
         $display("FAIL old_data_cleared got %b required 0000", p);
      end
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear got %b required 0", overrun);
      end
   endtask

   task automatic test_skip_transparent();
      logic [3:0] p;
      logic v;
      logic [3:0] exp_pix;
`ifdef SKIP_TRANSPARENT_EN
      exp_pix = 4'b0101;
`else
      exp_pix = 4'b0000;
`endif
      wait_ready();
      push(6'd3, 6'd3, 4'b0101);
      push(6'd3, 6'd3, 4'b0000);
      sif.i_valid = 1'b0;
      tick();
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL transparent_frame_done got %b required 1", frame_done);
      end
      do_read(6'd3, 6'd3, p, v);
      checks++;
      if (p !== 4'b1100) begin
         errors++;
         $display("FAIL read_in_swap got %b required 1100", p);
      end
      do_read(6'd3, 6'd3, p, v);
      checks++;
      if (p !== exp_pix) begin
         errors++;
         $display("FAIL transparent_write got %b required %b", p, exp_pix);
      end
   endtask

   task automatic test_reset_midfill();
      wait_ready();
      push(6'd9, 6'd9, 4'b0110);
      rd_en = 1'b1;
      rd_h  = 6'd3;
      rd_v  = 6'd3;
      push(6'd9, 6'd9, 4'b0110);
      rd_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({sif.o_ready, frame_done, overrun, rd_pixel, rd_valid, disp_valid} !== 9'b0) begin
         errors++;
         $display("FAIL midfill_reset got ready=%b fd=%b ovr=%b pix=%h rv=%b dv=%b required all 0",
                  sif.o_ready, frame_done, overrun, rd_pixel, rd_valid, disp_valid);
      end
      sif.i_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (sif.o_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_after_reset got ready=%b required 0", sif.o_ready);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      clr_overrun = 1'b0;
      rd_en = 1'b0;
      rd_h = '0;
      rd_v = '0;
      sif.i_valid = 1'b0;
      sif.i_H_transformed = '0;
      sif.i_V_transformed = '0;
      sif.i_encoded_pixel = '0;
      test_reset();
      test_frame_basic();
      test_second_frame();
      test_overrun();
      test_duplicate();
      test_skip_transparent();
      test_reset_midfill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
